// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD seven-segment display multiplexer.
// Segment codes are active-low, bit 6 = g ... bit 0 = a.
package bcd_disp_pkg;

   localparam int unsigned NDIG = 4;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15 show a dash.
module bcd_to_sseg
   import bcd_disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_disp_mux.sv
// Captures four BCD digits plus decimal points and scans them onto a 4-digit
// common-anode display. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_disp_mux
   import bcd_disp_pkg::*;
#(
   parameter int unsigned N = 18
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] bcd3,
   input  logic [3:0] bcd2,
   input  logic [3:0] bcd1,
   input  logic [3:0] bcd0,
   input  logic [3:0] dp_in,
   output logic [3:0] an,
   output logic [7:0] sseg
);

   logic [N-1:0]            q_q;
   logic [NDIG-1:0][3:0]    digit_q;
   logic [NDIG-1:0]         dp_q;
   logic [3:0]              an_q, an_d;
   logic [7:0]              sseg_q, sseg_d;
   logic [1:0]              sel;
   logic [6:0]              seg;
   logic [NDIG-1:0]         blank;

   assign sel = q_q[N-1:N-2];

   bcd_to_sseg u_dec (
      .bcd (digit_q[sel]),
      .seg (seg)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // A digit blanks only if it and every digit above it are zero without a dp.
   always_comb begin
      blank    = '0;
      blank[3] = (digit_q[3] == 4'd0) && !dp_q[3];
      blank[2] = blank[3] && (digit_q[2] == 4'd0) && !dp_q[2];
      blank[1] = blank[2] && (digit_q[1] == 4'd0) && !dp_q[1];
      blank[0] = 1'b0;
   end
`else
   assign blank = '0;
`endif

   always_comb begin
      an_d   = ~(4'b0001 << sel);
      sseg_d = {~dp_q[sel], seg};
      if (blank[sel]) begin
         an_d   = 4'hF;
         sseg_d = {1'b1, SEG_OFF};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q     <= '0;
         digit_q <= '0;
         dp_q    <= '0;
         an_q    <= 4'hF;
         sseg_q  <= 8'hFF;
      end else begin
         q_q    <= q_q + N'(1);
         an_q   <= an_d;
         sseg_q <= sseg_d;
         if (load) begin
            digit_q <= {bcd3, bcd2, bcd1, bcd0};
            dp_q    <= dp_in;
         end
      end
   end

   assign an   = an_q;
   assign sseg = sseg_q;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Scoreboard bench for bcd_disp_mux (N=4); honours LEADING_ZERO_BLANK_EN.
module tb_bcd_disp_mux;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [3:0] bcd3 = '0, bcd2 = '0, bcd1 = '0, bcd0 = '0;
   logic [3:0] dp_in = '0;
   logic [3:0] an;
   logic [7:0] sseg;

   int total = 0;
   int bad = 0;

   logic [11:0] sb[$];

   // Reference state: counter, shadow digits and dp as the spec defines them.
   int unsigned    m_q = 0;
   logic [15:0]    m_dig = '0;
   logic [3:0]     m_dp = '0;

   bcd_disp_mux #(.N(4)) dut (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .bcd3  (bcd3),
      .bcd2  (bcd2),
      .bcd1  (bcd1),
      .bcd0  (bcd0),
      .dp_in (dp_in),
      .an    (an),
      .sseg  (sseg)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   function automatic logic [11:0] expect_out();
      int k;
      logic [3:0] d;
      logic [3:0] blk;
      k = int'(m_q / 4);
      d = m_dig[k*4 +: 4];
      blk = '0;
`ifdef LEADING_ZERO_BLANK_EN
      blk[3] = (m_dig[15:12] == 4'd0) && !m_dp[3];
      blk[2] = blk[3] && (m_dig[11:8] == 4'd0) && !m_dp[2];
      blk[1] = blk[2] && (m_dig[7:4] == 4'd0) && !m_dp[1];
`endif
      if (blk[k]) return {4'hF, 8'hFF};
      return {~(4'b0001 << k), ~m_dp[k], seg_of(d)};
   endfunction

   // Drive one cycle of stimulus and push the output expected after its edge.
   task automatic step(input logic r, input logic l, input logic [15:0] b, input logic [3:0] d);
      @(negedge clk);
      reset = r;
      load  = l;
      {bcd3, bcd2, bcd1, bcd0} = b;
      dp_in = d;
      if (r) sb.push_back({4'hF, 8'hFF});
      else   sb.push_back(expect_out());
      if (r) begin
         m_q = 0;
         m_dig = '0;
         m_dp = '0;
      end else begin
         m_q = (m_q + 1) % 16;
         if (l) begin
            m_dig = b;
            m_dp = d;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'hEEEE, 4'hF);
   endtask

   initial begin : monitor
      logic [11:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if ({an, sseg} !== e) begin
               bad++;
               $display("FAIL out t=%0t an=%b sseg=%h required an=%b sseg=%h",
                        $time, an, sseg, e[11:8], e[7:0]);
            end
         end
      end
   end

   initial begin : driver
      int guard;
      // Reset with a simultaneous load: reset must win.
      step(1'b1, 1'b1, 16'h9999, 4'hF);
      step(1'b1, 1'b1, 16'h9999, 4'hF);
      idle(16);
      step(1'b0, 1'b1, 16'h1234, 4'b0100);
      idle(32);
      step(1'b0, 1'b1, 16'h123C, 4'b0000);
      idle(16);
      step(1'b0, 1'b1, 16'h5678, 4'b1111);
      idle(16);
      step(1'b0, 1'b1, 16'hABDE, 4'b0010);
      idle(16);
      // Load a new hundreds digit while digit 2 is lit.
      guard = 0;
      while (m_q != 9 && guard < 20) begin
         idle(1);
         guard++;
      end
      step(1'b0, 1'b1, 16'hA9DE, 4'b0010);
      idle(16);
      step(1'b1, 1'b1, 16'h8888, 4'hF);
      idle(16);
      step(1'b0, 1'b1, 16'h0070, 4'b0000);
      idle(16);
      step(1'b0, 1'b1, 16'h0000, 4'b1000);
      idle(16);
      step(1'b0, 1'b1, 16'h0005, 4'b0000);
      idle(16);
      repeat (3) @(posedge clk);
      #2;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain leftover=%0d required=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
